// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage SimpleRISC pipeline: load-use stall,
// taken-branch redirect/flush and multi-cycle EX busy. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] of_rs1,
  input  logic [REG_W-1:0] of_rs2,
  input  logic             of_use1,
  input  logic             of_use2,
  input  logic             ex_is_ld,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic [PC_W-1:0]  ex_br_pc,
  input  logic             ex_busy,
  output logic             stop,
  output logic             isBranchTaken,
  output logic [PC_W-1:0]  branchPC,
  output logic             ifof_hold,
  output logic             ofex_bubble,
  output logic             flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    BUSY  = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  tgt_q, tgt_d;
  logic             lu;
  logic             br_acc;

  assign lu = ex_is_ld & ((of_use1 & (of_rs1 == ex_rd)) | (of_use2 & (of_rs2 == ex_rd)));
  // EX holds a bubble during REDIR, so a branch flag seen there is stale and must not re-redirect.
  assign br_acc = ex_br_taken & (state_q != REDIR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d       = RUN;
    tgt_d         = tgt_q;
    stop          = 1'b0;
    ifof_hold     = 1'b0;
    ofex_bubble   = 1'b0;
    isBranchTaken = 1'b0;
    flush         = 1'b0;

    if (br_acc) begin
      state_d = REDIR;
      tgt_d   = ex_br_pc;
    end else if (ex_busy) begin
      state_d = BUSY;
    end else if (lu && (state_q == RUN)) begin
      state_d = LDUSE;
    end

    case (state_q)
      RUN: begin
        stop        = lu & ~ex_br_taken & ~ex_busy;
        ifof_hold   = stop;
        ofex_bubble = stop;
      end
      BUSY: begin
        stop      = 1'b1;
        ifof_hold = 1'b1;
      end
      REDIR: begin
        isBranchTaken = 1'b1;
        flush         = 1'b1;
      end
      default: ;
    endcase
  end

  assign branchPC = tgt_q;
  assign state_o  = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters: they stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stop && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if ((state_q == REDIR) && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
